// File: rtl/note_player_pkg.sv
// Shared word-format and playback constants for the recorder/player pair.
// The recorder side uses the same note field positions and length limit.
package note_player_pkg;

    localparam int NP_ADDR_W   = 6;
    localparam int NP_DATA_W   = 32;
    localparam int NP_NOTE_W   = 10;
    localparam int NP_NOTE_LSB = 0;
    localparam int NP_NOTE_MSB = NP_NOTE_LSB + NP_NOTE_W - 1;
    localparam int NP_LEN_W    = 7;
    localparam int NP_MAX_LEN  = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WAIT_BEAT = 3'd3,
        ST_DRAIN     = 3'd4
    } play_state_t;

    function automatic logic [NP_LEN_W-1:0] clamp_len(input logic [NP_LEN_W-1:0] len);
        return (len > NP_LEN_W'(NP_MAX_LEN)) ? NP_LEN_W'(NP_MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/note_player.sv
// Playback engine: prefetches one note word per beat from the note RAM and
// presents it on the beat tick, with single-shot or looped playback.
module note_player
    import note_player_pkg::*;
#(
    parameter int ADDR_W = NP_ADDR_W,
    parameter int DATA_W = NP_DATA_W,
    parameter int NOTE_W = NP_NOTE_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic                beat_tick,
    input  logic [NP_LEN_W-1:0] rec_length,
    input  logic [DATA_W-1:0]   ram_q,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [NOTE_W-1:0]   note_out,
    output logic                note_strobe,
    output logic                playing,
    output logic                done
);

    play_state_t         r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [NP_LEN_W-1:0] r_len;
    logic [NOTE_W-1:0]   r_buf;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [NOTE_W-1:0]   r_note;
    logic                r_strobe;
    logic                r_playing;
    logic                r_done;

    play_state_t         w_next_state;
    logic [ADDR_W-1:0]   w_next_index;
    logic [NP_LEN_W-1:0] w_next_len;
    logic [NP_LEN_W-1:0] w_len_clamped;
    logic                w_last;
    logic                w_load_note;
    logic                w_clr_note;
    logic                w_strobe;
    logic                w_done;
    logic                w_unused_ram_hi;

    assign w_len_clamped   = clamp_len(rec_length);
    assign w_last          = (NP_LEN_W'(r_index) == (r_len - NP_LEN_W'(1)));
    assign w_unused_ram_hi = ^ram_q[DATA_W-1:NOTE_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_len      <= '0;
            r_ram_addr <= '0;
            r_note     <= '0;
            r_strobe   <= 1'b0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_index    <= w_next_index;
            r_len      <= w_next_len;
            r_ram_addr <= (w_next_state == ST_IDLE) ? '0 : w_next_index;
            r_strobe   <= w_strobe;
            r_playing  <= (w_next_state != ST_IDLE);
            r_done     <= w_done;
            if (w_load_note)
                r_note <= r_buf;
            else if (w_clr_note)
                r_note <= '0;
        end
    end

    // RAM data for the address presented in READ is valid during CAPTURE
    always_ff @(posedge clk) begin
        if (r_state == ST_CAPTURE)
            r_buf <= ram_q[NOTE_W-1:0];
    end

    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_next_len   = r_len;
        w_load_note  = 1'b0;
        w_clr_note   = 1'b0;
        w_strobe     = 1'b0;
        w_done       = 1'b0;
        if (r_state == ST_IDLE) begin
            if (start) begin
                if (w_len_clamped == '0) begin
                    w_done = 1'b1;
                end else begin
                    w_next_len   = w_len_clamped;
                    w_next_index = '0;
                    w_next_state = ST_READ;
                end
            end
        end else if (stop) begin
            w_next_state = ST_IDLE;
            w_clr_note   = 1'b1;
        end else begin
            case (r_state)
                ST_READ:    w_next_state = ST_CAPTURE;
                ST_CAPTURE: w_next_state = ST_WAIT_BEAT;
                ST_WAIT_BEAT: begin
                    if (beat_tick) begin
                        w_load_note = 1'b1;
                        w_strobe    = 1'b1;
                        // Wrap is explicit so a 64-word take never rolls the index over
                        if (w_last) begin
                            if (loop) begin
                                w_next_index = '0;
                                w_next_state = ST_READ;
                            end else begin
                                w_next_state = ST_DRAIN;
                            end
                        end else begin
                            w_next_index = r_index + ADDR_W'(1);
                            w_next_state = ST_READ;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat_tick) begin
                        w_clr_note   = 1'b1;
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign ram_addr    = r_ram_addr;
    assign note_out    = r_note;
    assign note_strobe = r_strobe;
    assign playing     = r_playing;
    assign done        = r_done;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: the stimulus predicts each note/done event
// from the recorded words and tick count; a monitor consumes the DUT events.
module tb_note_player;
    import note_player_pkg::*;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 start;
    logic                 stop;
    logic                 loop;
    logic                 beat_tick;
    logic [NP_LEN_W-1:0]  rec_length;
    logic [NP_DATA_W-1:0] ram_q;
    logic [NP_ADDR_W-1:0] ram_addr;
    logic [NP_NOTE_W-1:0] note_out;
    logic                 note_strobe;
    logic                 playing;
    logic                 done;

    always #5 clk = ~clk;

    note_player dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .loop(loop),
        .beat_tick(beat_tick), .rec_length(rec_length), .ram_q(ram_q),
        .ram_addr(ram_addr), .note_out(note_out), .note_strobe(note_strobe),
        .playing(playing), .done(done)
    );

    logic [NP_DATA_W-1:0] mem [NP_MAX_LEN];
    always @(posedge clk) ram_q <= mem[ram_addr];

    typedef struct packed {
        logic                 is_done;
        logic [NP_NOTE_W-1:0] note;
    } ev_t;

    ev_t exp_q[$];
    int  chk = 0;
    int  err = 0;
    int  cur_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (resetn) begin
            if (playing)
                check("addr_in_range", (int'(ram_addr) < cur_len) ? 1 : 0, 1);
            if (note_strobe || done) begin
                if (exp_q.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL unexpected_event strobe=%0b done=%0b note=%0h required=none at %0t",
                             note_strobe, done, note_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event_done", done, e.is_done);
                    check("event_strobe", note_strobe, !e.is_done);
                    check("note_out", note_out, e.is_done ? '0 : e.note);
                    if (e.is_done)
                        check("playing_at_done", playing, 0);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP_MAX_LEN; i++) mem[i] = $urandom;
    endtask

    task automatic play(input int rl, input bit lp, input int nticks, input bit perturb);
        int eff;
        eff     = (rl > NP_MAX_LEN) ? NP_MAX_LEN : rl;
        cur_len = eff;
        loop    = lp;
        if (eff == 0) exp_q.push_back(ev_t'{1'b1, 10'd0});
        rec_length = NP_LEN_W'(rl);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("playing_after_start", playing, (eff != 0) ? 1 : 0);
        if (eff == 0) begin
            check("addr_len0", ram_addr, 0);
            cyc(3);
            check("playing_len0", playing, 0);
            check("addr_len0_after", ram_addr, 0);
            return;
        end
        for (int k = 0; k < nticks; k++) begin
            cyc(19);
            if (perturb && k == 1) begin
                rec_length = NP_LEN_W'($urandom);
                start = 1'b1;
                cyc(1);
                start = 1'b0;
            end
            if (lp || k < eff)
                exp_q.push_back(ev_t'{1'b0, mem[k % eff][NP_NOTE_W-1:0]});
            else if (k == eff)
                exp_q.push_back(ev_t'{1'b1, 10'd0});
            beat_tick = 1'b1;
            cyc(1);
            beat_tick = 1'b0;
        end
        cyc(5);
    endtask

    task automatic stop_now(input bit with_tick);
        stop      = 1'b1;
        beat_tick = with_tick;
        cyc(1);
        stop      = 1'b0;
        beat_tick = 1'b0;
        check("stop_playing", playing, 0);
        check("stop_note", note_out, 0);
        check("stop_strobe", note_strobe, 0);
        check("stop_done", done, 0);
        cyc(3);
    endtask

    initial begin
        int rl, eff, nt;
        bit lp;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        beat_tick = 1'b0; rec_length = '0;
        fill_random();
        cyc(3);
        check("rst_addr", ram_addr, 0);
        check("rst_note", note_out, 0);
        check("rst_strobe", note_strobe, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;
        cyc(2);

        mem[0] = {22'($urandom), 10'h001};
        mem[1] = {22'($urandom), 10'h002};
        mem[2] = {22'($urandom), 10'h004};
        play(3, 1'b0, 4, 1'b0);
        check("single_end_playing", playing, 0);

        play(3, 1'b1, 8, 1'b0);
        stop_now(1'b0);

        play(0, 1'b0, 0, 1'b0);

        for (int i = 0; i < NP_MAX_LEN; i++) mem[i] = NP_DATA_W'(i);
        play(64, 1'b0, 65, 1'b0);
        check("len64_end_playing", playing, 0);

        play(3, 1'b1, 2, 1'b0);
        stop_now(1'b1);

        fill_random();
        play(100, 1'b0, 65, 1'b1);
        check("clamp_end_playing", playing, 0);

        play(5, 1'b1, 3, 1'b0);
        resetn = 1'b0;
        cyc(1);
        check("midrst_addr", ram_addr, 0);
        check("midrst_note", note_out, 0);
        check("midrst_strobe", note_strobe, 0);
        check("midrst_playing", playing, 0);
        check("midrst_done", done, 0);
        resetn = 1'b1;
        cyc(2);

        repeat (6) begin
            fill_random();
            rl  = $urandom_range(0, 127);
            eff = (rl > NP_MAX_LEN) ? NP_MAX_LEN : rl;
            lp  = 1'($urandom);
            if (eff == 0)
                nt = 0;
            else if (lp)
                nt = $urandom_range(1, 2 * eff);
            else
                nt = eff + 1;
            play(rl, lp, nt, 1'($urandom));
            if (lp)
                stop_now(1'($urandom));
            else
                check("rand_end_playing", playing, 0);
        end

        cyc(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/note_player.md
# note_player

Playback engine of the recorder: reads the note words written into the 64 x 32 note RAM and presents them one per beat on the note outputs. It is the reader counterpart of the recording address counter and shares the same RAM port through a top-level address mux. Beat pacing comes from the existing beat divider's one-cycle tick, so playback runs at the same tempo selection as recording. Supports single-shot and looped playback, stop, and a completion pulse.

## Interface
- ADDR_W, 6, RAM address width (64 words)
- DATA_W, 32, RAM word width
- NOTE_W, 10, note field width (one bit per key switch)
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin playback from word 0
- stop  in  1  one-cycle request to abort playback
- loop  in  1  sampled at each wrap decision; 1 = restart at word 0 after last word
- beat_tick  in  1  one-cycle pulse per beat from the beat divider
- rec_length  in  7  number of recorded words, 0..64; values > 64 treated as 64
- ram_q  in  DATA_W  RAM read data, valid one cycle after ram_addr
- ram_addr  out  ADDR_W  RAM read address
- note_out  out  NOTE_W  currently sounding note mask
- note_strobe  out  1  one-cycle pulse when note_out takes a new word
- playing  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at natural end of non-looped playback

## Operation
- Word format: ram_q[NOTE_W-1:0] = note mask; ram_q[DATA_W-1:NOTE_W] ignored.
- Internal: index (ADDR_W), prefetch buffer (NOTE_W), length latched at start (7 bits, clamped).
- States: IDLE, READ, CAPTURE, WAIT_BEAT, DRAIN.
- IDLE: ram_addr=0, note_out=0. start with clamped rec_length != 0: latch length, index<=0, -> READ. start with rec_length == 0: done pulses, stay IDLE.
- READ: ram_addr=index held; -> CAPTURE.
- CAPTURE: buffer <= ram_q[NOTE_W-1:0]; -> WAIT_BEAT.
- WAIT_BEAT: on beat_tick: note_out <= buffer, note_strobe=1 next cycle. If index == length-1: loop=1 -> index<=0, READ; loop=0 -> DRAIN. Else index<=index+1, READ.
- DRAIN: last note holds; on beat_tick: note_out<=0, done=1, -> IDLE.
- stop in any non-IDLE state: next cycle note_out=0, -> IDLE, no done, no note_strobe. stop has priority over beat_tick and start in the same cycle.
- start while not IDLE: ignored.
- beat_tick in IDLE, READ or CAPTURE: ignored (beat period is at least 13.6M cycles, so the 2-cycle prefetch never misses a tick after the first).
- length 64: index reaches 63, no address overflow; wrap is explicit via the loop path, never by counter rollover.
- rec_length changes during playback have no effect (latched value used).

## Timing
- Reset values: ram_addr=0, note_out=0, note_strobe=0, playing=0, done=0, state IDLE, index=0.
- All outputs registered.
- start at edge N -> playing=1 and READ at N+1, CAPTURE at N+2, WAIT_BEAT at N+3.
- beat_tick sampled at edge M in WAIT_BEAT -> note_out/note_strobe updated at M+1; next word prefetched by M+3.
- RAM read latency fixed at 1 cycle; ram_addr stable through READ and CAPTURE.
- done is asserted for exactly one cycle, coincident with playing falling.

## Structure
- Shared package: state encoding localparams, NOTE_W/ADDR_W/DATA_W, note field bit positions, max length 64. The recorder side uses the same word-format constants.
- Single module, no sub-module; the RAM and the read/write address mux stay at top level.

## Test plan
- rec_length=3, RAM words 0..2 = 10'h001, 10'h002, 10'h004, loop=0, ticks every 20 cycles -> note_out 001, 002, 004 on three successive ticks with one note_strobe each, 0 plus done on fourth tick, playing falls.
- Same data, loop=1 -> sequence 001,002,004,001,... for 8 ticks; done never asserted.
- rec_length=0, start -> done pulses next cycle, playing stays 0, ram_addr stays 0.
- Playback of 64 words with ram word i = i -> note_out steps 0..63, ram_addr never exceeds 63, done after 64th note is released.
- stop asserted in the same cycle as beat_tick mid-playback -> note_out=0, no note_strobe, IDLE next cycle; resetn low mid-playback -> all outputs at reset values next edge.
